pipe_hold_ctrl: RTL and testbench
=================================

Name: pipe_hold_ctrl

Overview:
- Central pipeline hold/flush controller for the core.
- Merges hold requests from execute (multi-cycle ops), the bus interconnect (RIB busy) and the interrupt controller (CLINT) with execute-stage jump requests.
- Drives the single hold_flag bus consumed by pc_reg, if_id and id_ex.
- Stretches every jump into a programmable multi-cycle flush, so NOPs cover the fetch latency after a redirect.

Parameters:
- FLUSH_CYCLES, 1, number of extra cycles of Hold_If after the jump cycle (legal range 0..15).
- HOLD_TIMEOUT, 1023, consecutive request-hold cycles before the watchdog flags a stall (legal range 1..65535).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- jump_flag_i  in  1  jump/branch-taken request from execute
- jump_addr_i  in  32  jump target
- hold_ex_i  in  1  execute multi-cycle hold request
- hold_rib_i  in  1  bus-busy hold request
- hold_clint_i  in  1  interrupt-entry hold request
- timeout_clr_i  in  1  clears the sticky timeout flag
- hold_flag_o  out  3  encoded hold level to pipeline registers
- jump_flag_o  out  1  PC redirect strobe
- jump_addr_o  out  32  PC redirect target
- flush_busy_o  out  1  post-jump flush in progress
- hold_timeout_o  out  1  sticky stall watchdog flag

Behaviour:
- Hold levels: Hold_None=3'd0, Hold_Pc=3'd1, Hold_If=3'd2, Hold_Id=3'd3.
  - A stage register flushes to its default when hold_flag >= its level.
- Request mapping:
  - hold_ex_i -> Hold_Id.
  - hold_clint_i -> Hold_Id.
  - hold_rib_i -> Hold_Pc.
  - jump_flag_i -> Hold_Id.
  - FLUSH state -> Hold_If.
- hold_flag_o is the numeric max of all active levels. It is combinational from the inputs plus registered state, with zero-cycle latency.
- jump_flag_o and jump_addr_o pass jump_flag_i and jump_addr_i through combinationally.
  - jump_addr_o = 0 when jump_flag_i = 0.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH when jump_flag_i=1 and FLUSH_CYCLES>0. The 4-bit flush_cnt loads FLUSH_CYCLES.
  - FLUSH: flush_cnt decrements each cycle. FLUSH -> IDLE when flush_cnt reaches 1 and no new jump arrives.
  - Jump in FLUSH: flush_cnt reloads to FLUSH_CYCLES and the state stays FLUSH. The new target passes through the same cycle.
  - FLUSH_CYCLES=0: the FSM never leaves IDLE, and a jump flushes only in its own cycle.
- flush_busy_o = (state == FLUSH), registered.
- Simultaneous events:
  - Jump together with a hold request: output is still the max, so Hold_Id. The flush still starts.
  - A hold request during FLUSH raises the level above Hold_If only if the request's own level is higher. The flush counter keeps counting regardless.
- Reset (asynchronous, rst=0), including mid-flush:
  - State IDLE, flush_cnt=0, watchdog counter=0.
  - hold_flag_o=0, flush_busy_o=0, hold_timeout_o=0.
  - jump outputs follow their inputs.

Optional Feature:
- Macro: PIPE_HOLD_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments every cycle any of hold_ex_i, hold_rib_i or hold_clint_i is high.
  - The counter clears to 0 in any cycle where all three are low.
  - When the counter equals HOLD_TIMEOUT, hold_timeout_o sets on the next edge and stays set. The counter saturates.
  - timeout_clr_i=1 clears both the flag and the counter. The clear wins over a same-cycle set.
- Undefined: no counter is built, hold_timeout_o is tied 0, and timeout_clr_i is ignored.

Decomposition:
- Shared defines package (existing defines file) holds:
  - Hold_None, Hold_Pc, Hold_If, Hold_Id;
  - Hold_Flag_Bus width (3);
  - InstAddrBus;
  - FSM state encodings PIPE_IDLE and PIPE_FLUSH.
- One sub-module: hold_watchdog. It contains the counter and sticky flag and is instantiated only under PIPE_HOLD_TIMEOUT_EN.
- All flops use gen_pipe_dff-style async reset cells.

Test Plan:
- Reset release, no requests -> hold_flag_o=0, flush_busy_o=0, jump_flag_o=0 for 10 cycles.
- hold_rib_i=1 for 3 cycles -> hold_flag_o=3'd1 in exactly those 3 cycles, with no flush.
- jump_flag_i pulse (1 cycle, addr 0x0000_0100), FLUSH_CYCLES=2:
  - jump cycle: hold_flag_o=3'd3, jump_addr_o=0x100;
  - next 2 cycles: 3'd2 with flush_busy_o=1;
  - then 0.
- Second jump (addr 0x200) in the first FLUSH cycle -> counter reloads, 2 more Hold_If cycles after that jump, jump_addr_o=0x200 that cycle.
- hold_ex_i=1 concurrent with FLUSH -> hold_flag_o=3'd3 while hold_ex_i is high, 3'd2 for the remaining flush cycles. Then assert rst=0 mid-flush -> all outputs 0 immediately, asynchronously.
- With PIPE_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=8:
  - hold_clint_i high 8 cycles -> hold_timeout_o=1 after the 8th cycle's edge;
  - timeout_clr_i pulse -> 0;
  - a 7-cycle hold, a 1-cycle gap, then another 7-cycle hold -> never set.

Source files
------------

// File: rtl/pipe_hold_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hold_ctrl_pkg
// Description : Shared pipeline defines: hold levels, bus widths, FSM states
//               and a small max helper for combining hold requests.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hold_ctrl_pkg;

  // Width of the encoded hold bus seen by pc_reg, if_id and id_ex
  localparam int Hold_Flag_Bus = 3;
  // Instruction address bus width
  localparam int InstAddrBus   = 32;

  // Hold levels: a stage flushes to its default when hold_flag >= its level
  localparam logic [Hold_Flag_Bus-1:0] Hold_None = 3'd0;
  localparam logic [Hold_Flag_Bus-1:0] Hold_Pc   = 3'd1;
  localparam logic [Hold_Flag_Bus-1:0] Hold_If   = 3'd2;
  localparam logic [Hold_Flag_Bus-1:0] Hold_Id   = 3'd3;

  // Post-jump flush sequencer states
  typedef enum logic [0:0] {
    PIPE_IDLE  = 1'b0,
    PIPE_FLUSH = 1'b1
  } pipe_state_e;

  // Numeric max of two hold levels
  function automatic logic [Hold_Flag_Bus-1:0] hold_max(
    input logic [Hold_Flag_Bus-1:0] a,
    input logic [Hold_Flag_Bus-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hold_ctrl_hold_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : hold_watchdog
// Description : Counts consecutive cycles with any hold request active and
//               raises a sticky stall flag once the run reaches HOLD_TIMEOUT.
//               The counter saturates; a clear wins over a same-cycle set.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_watchdog #(
  parameter int HOLD_TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_any_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam logic [15:0] C_LIMIT = 16'(HOLD_TIMEOUT);

  logic [15:0] cnt_q, cnt_d;
  logic        flag_q, flag_d;

  // Next-state: count held cycles, restart on any idle cycle, saturate at limit.
  // The flag fires on the same edge the count reaches the limit.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clr_i) begin
      cnt_d  = 16'd0;
      flag_d = 1'b0;
    end else begin
      if (!hold_any_i) begin
        cnt_d = 16'd0;
      end else if (cnt_q != C_LIMIT) begin
        cnt_d = cnt_q + 16'd1;
      end
      if (hold_any_i && (cnt_d == C_LIMIT)) begin
        flag_d = 1'b1;
      end
    end
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 16'd0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hold_ctrl
// Description : Central pipeline hold/flush controller. Merges execute, bus
//               and interrupt hold requests with jump requests into a single
//               hold level and stretches each jump into a FLUSH_CYCLES-long
//               Hold_If flush. Optional stall watchdog built when the macro
//               PIPE_HOLD_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int HOLD_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     jump_flag_i,
  input  logic [InstAddrBus-1:0]   jump_addr_i,
  input  logic                     hold_ex_i,
  input  logic                     hold_rib_i,
  input  logic                     hold_clint_i,
  input  logic                     timeout_clr_i,
  output logic [Hold_Flag_Bus-1:0] hold_flag_o,
  output logic                     jump_flag_o,
  output logic [InstAddrBus-1:0]   jump_addr_o,
  output logic                     flush_busy_o,
  output logic                     hold_timeout_o
);

  localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES);

  pipe_state_e state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [Hold_Flag_Bus-1:0] lvl_id, lvl_pc, lvl_if, lvl_max;

  // Flush sequencer next state: a jump (re)loads the counter; the last
  // counted cycle returns to idle unless another jump arrives.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      PIPE_IDLE: begin
        if (jump_flag_i && (C_FLUSH_LOAD != 4'd0)) begin
          state_d     = PIPE_FLUSH;
          flush_cnt_d = C_FLUSH_LOAD;
        end
      end
      PIPE_FLUSH: begin
        if (jump_flag_i) begin
          flush_cnt_d = C_FLUSH_LOAD;
        end else if (flush_cnt_q <= 4'd1) begin
          state_d     = PIPE_IDLE;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = PIPE_IDLE;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  // Flush state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PIPE_IDLE;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Hold level is the max of every active request; forced to none in reset
  assign lvl_id  = (hold_ex_i || hold_clint_i || jump_flag_i) ? Hold_Id : Hold_None;
  assign lvl_pc  = hold_rib_i ? Hold_Pc : Hold_None;
  assign lvl_if  = (state_q == PIPE_FLUSH) ? Hold_If : Hold_None;
  assign lvl_max = hold_max(lvl_id, hold_max(lvl_pc, lvl_if));

  assign hold_flag_o  = rst_n ? lvl_max : Hold_None;
  assign flush_busy_o = (state_q == PIPE_FLUSH);
  assign jump_flag_o  = jump_flag_i;
  assign jump_addr_o  = jump_flag_i ? jump_addr_i : '0;

`ifdef PIPE_HOLD_TIMEOUT_EN
  hold_watchdog #(
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) u_hold_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_any_i (hold_ex_i | hold_rib_i | hold_clint_i),
    .clr_i      (timeout_clr_i),
    .timeout_o  (hold_timeout_o)
  );
`else
  // Watchdog not built: flag tied low, clear input and limit have no effect
  logic unused_wdog;
  assign unused_wdog    = timeout_clr_i ^ (HOLD_TIMEOUT == 0);
  assign hold_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipe_hold_ctrl
// Description : Scoreboard bench for pipe_hold_ctrl: a driver applies each
//               cycle's inputs and queues the expected outputs from a
//               behavioural model; a monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hold_ctrl;

  localparam int FC = 2;
  localparam int TO = 8;
`ifdef PIPE_HOLD_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i, hold_rib_i, hold_clint_i, timeout_clr_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        flush_busy_o, hold_timeout_o;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(
    .FLUSH_CYCLES (FC),
    .HOLD_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .hold_ex_i      (hold_ex_i),
    .hold_rib_i     (hold_rib_i),
    .hold_clint_i   (hold_clint_i),
    .timeout_clr_i  (timeout_clr_i),
    .hold_flag_o    (hold_flag_o),
    .jump_flag_o    (jump_flag_o),
    .jump_addr_o    (jump_addr_o),
    .flush_busy_o   (flush_busy_o),
    .hold_timeout_o (hold_timeout_o)
  );

  typedef struct {
    logic [2:0]  lvl;
    logic        jf;
    logic [31:0] ja;
    logic        busy;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: remaining flush cycles, current held-run length, sticky flag
  int flush_rem = 0;
  int run_len   = 0;
  bit flag      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue expectation,
  // then advance the model across the next edge.
  task automatic step(input bit ex, input bit rib, input bit clint, input bit jmp,
                      input logic [31:0] addr, input bit clr, input bit rstn);
    exp_t e;
    int   lvl;
    hold_ex_i     = ex;
    hold_rib_i    = rib;
    hold_clint_i  = clint;
    jump_flag_i   = jmp;
    jump_addr_i   = addr;
    timeout_clr_i = clr;
    rst_n         = rstn;
    if (!rstn) begin
      flush_rem = 0;
      run_len   = 0;
      flag      = 1'b0;
    end
    lvl = 0;
    if (rib) lvl = 1;
    if (flush_rem > 0 && lvl < 2) lvl = 2;
    if (ex || clint || jmp) lvl = 3;
    if (!rstn) lvl = 0;
    e.lvl  = 3'(lvl);
    e.jf   = jmp;
    e.ja   = jmp ? addr : 32'h0;
    e.busy = (flush_rem > 0);
    e.to   = flag;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rstn) begin
      if (jmp && FC > 0) flush_rem = FC;
      else if (flush_rem > 0) flush_rem--;
      if (WD) begin
        if (clr) begin
          run_len = 0;
          flag    = 1'b0;
        end else if (ex || rib || clint) begin
          run_len++;
          if (run_len >= TO) flag = 1'b1;
        end else begin
          run_len = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0, 1);
  endtask

  // Monitor: compare DUT outputs half a cycle after the driver applied inputs
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hold_flag",    32'(hold_flag_o),    32'(e.lvl));
      chk("jump_flag",    32'(jump_flag_o),    32'(e.jf));
      chk("jump_addr",    jump_addr_o,         e.ja);
      chk("flush_busy",   32'(flush_busy_o),   32'(e.busy));
      chk("hold_timeout", 32'(hold_timeout_o), 32'(e.to));
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0; jump_flag_i = 0; jump_addr_i = 0;
    hold_ex_i = 0; hold_rib_i = 0; hold_clint_i = 0; timeout_clr_i = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    // Reset release, quiet pipeline
    idle(10);
    // Bus busy for three cycles
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 0, 1);
    idle(2);
    // Single jump followed by its flush
    step(0, 0, 0, 1, 32'h0000_0100, 0, 1);
    idle(4);
    // Second jump in the first flush cycle reloads the flush
    step(0, 0, 0, 1, 32'h0000_0100, 0, 1);
    step(0, 0, 0, 1, 32'h0000_0200, 0, 1);
    idle(4);
    // Jump plus concurrent hold, then execute hold during flush
    step(1, 1, 0, 1, 32'h0000_0300, 0, 1);
    step(1, 0, 0, 0, 32'h0000_0000, 0, 1);
    idle(3);
    // Asynchronous reset mid-flush with a hold still requested
    step(0, 0, 0, 1, 32'h0000_0400, 0, 1);
    step(1, 0, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 0);
    idle(2);
    // Watchdog: 8 held cycles set the flag, a clear drops it
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 32'h0, 1, 1);
    idle(2);
    // Two 7-cycle holds with a gap never reach the limit
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 32'h0, 0, 1);
    idle(1);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 32'h0, 0, 1);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 5) == 0, ($urandom % 4) == 0, ($urandom % 7) == 0,
           ($urandom % 6) == 0, $urandom, ($urandom % 25) == 0,
           ($urandom % 80) != 0);
    end
    idle(3);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
